// File: rtl/fp_cmp_minmax_d_if.sv
// Handshake bus for the double-precision compare/min/max unit.
// The issue side drives through master; the unit sits on slave.
interface fp_cmp_minmax_d_if;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_a;
    logic [63:0] in_b;
    logic [2:0]  in_op;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_result;
    logic [4:0]  out_fflags;

    modport slave (
        input  in_valid,
        input  in_a,
        input  in_b,
        input  in_op,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_result,
        output out_fflags
    );

    modport master (
        output in_valid,
        output in_a,
        output in_b,
        output in_op,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_result,
        input  out_fflags
    );
endinterface

// File: rtl/fp_cmp_minmax_d.sv
// Two-stage FEQ/FLT/FLE/FMIN/FMAX unit for binary64 operands.
// Zero/NaN/sNaN decisions come from the fp_class_d flag vectors of each operand.

// FCLASS-style classifier: one-hot {qNaN,sNaN,+inf,+norm,+sub,+0,-0,-sub,-norm,-inf}.
module fp_class_d (
    input  logic [63:0] i_x,
    output logic [9:0]  o_flags
);
    logic w_sign;
    logic w_exp_ones;
    logic w_exp_zero;
    logic w_man_zero;
    logic w_normal;

    assign w_sign     = i_x[63];
    assign w_exp_ones = &i_x[62:52];
    assign w_exp_zero = ~|i_x[62:52];
    assign w_man_zero = ~|i_x[51:0];
    assign w_normal   = !w_exp_ones && !w_exp_zero;

    assign o_flags[0] =  w_sign && w_exp_ones && w_man_zero;
    assign o_flags[1] =  w_sign && w_normal;
    assign o_flags[2] =  w_sign && w_exp_zero && !w_man_zero;
    assign o_flags[3] =  w_sign && w_exp_zero && w_man_zero;
    assign o_flags[4] = !w_sign && w_exp_zero && w_man_zero;
    assign o_flags[5] = !w_sign && w_exp_zero && !w_man_zero;
    assign o_flags[6] = !w_sign && w_normal;
    assign o_flags[7] = !w_sign && w_exp_ones && w_man_zero;
    assign o_flags[8] =  w_exp_ones && !w_man_zero && !i_x[51];
    assign o_flags[9] =  w_exp_ones && i_x[51];
endmodule

module fp_cmp_minmax_d #(
    parameter logic [63:0] CANON_NAN = 64'h7FF8000000000000
) (
    input  logic               clk,
    input  logic               rst,
    fp_cmp_minmax_d_if.slave   bus
);
    localparam logic [2:0] OP_FEQ  = 3'd0;
    localparam logic [2:0] OP_FLT  = 3'd1;
    localparam logic [2:0] OP_FLE  = 3'd2;
    localparam logic [2:0] OP_FMIN = 3'd3;
    localparam logic [2:0] OP_FMAX = 3'd4;

    logic [63:0] w_in_opnd [2];
    logic [9:0]  w_in_cls  [2];

    assign w_in_opnd[0] = bus.in_a;
    assign w_in_opnd[1] = bus.in_b;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cls
            fp_class_d u_cls (
                .i_x     (w_in_opnd[gi]),
                .o_flags (w_in_cls[gi])
            );
        end
    endgenerate

    logic        r_s1_valid;
    logic [63:0] r_s1_a;
    logic [63:0] r_s1_b;
    logic [2:0]  r_s1_op;
    logic [9:0]  r_s1_cls_a;
    logic [9:0]  r_s1_cls_b;
    logic        r_s2_valid;
    logic [63:0] r_out_result;
    logic [4:0]  r_out_fflags;

    logic w_s2_free;
    logic w_s1_adv;
    logic w_in_ready;
    logic w_in_fire;

    // Ready looks only at pipeline occupancy and out_ready, never at in_valid.
    assign w_s2_free  = !r_s2_valid || bus.out_ready;
    assign w_s1_adv   = r_s1_valid && w_s2_free;
    assign w_in_ready = !r_s1_valid || w_s2_free;
    assign w_in_fire  = bus.in_valid && w_in_ready;

    // Class-derived predicates for the operands held in S1.
    logic w_a_nan;
    logic w_b_nan;
    logic w_any_nan;
    logic w_both_nan;
    logic w_any_snan;
    logic w_both_zero;
    logic w_sign_a;
    logic w_sign_b;
    logic w_mag_lt;
    logic w_mag_gt;
    logic w_lt;
    logic w_eq;
    logic w_min_sel_a;
    logic w_max_sel_a;
    logic w_unused_cls;

    assign w_a_nan     = r_s1_cls_a[8] || r_s1_cls_a[9];
    assign w_b_nan     = r_s1_cls_b[8] || r_s1_cls_b[9];
    assign w_any_nan   = w_a_nan || w_b_nan;
    assign w_both_nan  = w_a_nan && w_b_nan;
    assign w_any_snan  = r_s1_cls_a[8] || r_s1_cls_b[8];
    assign w_both_zero = (r_s1_cls_a[3] || r_s1_cls_a[4]) && (r_s1_cls_b[3] || r_s1_cls_b[4]);
    assign w_sign_a    = r_s1_a[63];
    assign w_sign_b    = r_s1_b[63];
    assign w_mag_lt    = r_s1_a[62:0] < r_s1_b[62:0];
    assign w_mag_gt    = r_s1_a[62:0] > r_s1_b[62:0];
    assign w_unused_cls = ^{r_s1_cls_a[7:5], r_s1_cls_a[2:0], r_s1_cls_b[7:5], r_s1_cls_b[2:0]};

    always_comb begin
        w_lt = 1'b0;
        if (w_both_zero)
            w_lt = 1'b0;
        else if (w_sign_a != w_sign_b)
            w_lt = w_sign_a;
        else if (!w_sign_a)
            w_lt = w_mag_lt;
        else
            w_lt = w_mag_gt;
    end

    assign w_eq = w_both_zero || (r_s1_a == r_s1_b);

    // Mixed-sign zeros compare equal but still pick -0 for min and +0 for max.
    assign w_min_sel_a = w_both_zero ? w_sign_a  : (w_lt || w_eq);
    assign w_max_sel_a = w_both_zero ? !w_sign_a : !w_lt;

    logic [63:0] w_result;
    logic        w_nv;

    always_comb begin
        w_result = 64'd0;
        w_nv     = 1'b0;
        case (r_s1_op)
            OP_FEQ: begin
                w_result = {63'd0, !w_any_nan && w_eq};
                w_nv     = w_any_snan;
            end
            OP_FLT: begin
                w_result = {63'd0, !w_any_nan && w_lt};
                w_nv     = w_any_nan;
            end
            OP_FLE: begin
                w_result = {63'd0, !w_any_nan && (w_lt || w_eq)};
                w_nv     = w_any_nan;
            end
            OP_FMIN, OP_FMAX: begin
                if (w_both_nan)
                    w_result = CANON_NAN;
                else if (w_a_nan)
                    w_result = r_s1_b;
                else if (w_b_nan)
                    w_result = r_s1_a;
                else if (r_s1_op == OP_FMIN)
                    w_result = w_min_sel_a ? r_s1_a : r_s1_b;
                else
                    w_result = w_max_sel_a ? r_s1_a : r_s1_b;
                w_nv = w_any_snan;
            end
            default: begin
                w_result = 64'd0;
                w_nv     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid   <= 1'b0;
            r_s2_valid   <= 1'b0;
            r_out_result <= 64'd0;
            r_out_fflags <= 5'd0;
        end else begin
            if (w_in_fire) begin
                r_s1_a     <= bus.in_a;
                r_s1_b     <= bus.in_b;
                r_s1_op    <= bus.in_op;
                r_s1_cls_a <= w_in_cls[0];
                r_s1_cls_b <= w_in_cls[1];
                r_s1_valid <= 1'b1;
            end else if (w_s1_adv) begin
                r_s1_valid <= 1'b0;
            end

            if (w_s1_adv) begin
                r_s2_valid   <= 1'b1;
                r_out_result <= w_result;
                r_out_fflags <= {w_nv, 4'b0000};
            end else if (bus.out_ready) begin
                r_s2_valid <= 1'b0;
            end
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = r_s2_valid;
    assign bus.out_result = r_out_result;
    assign bus.out_fflags = r_out_fflags;
endmodule

// File: tb/tb_fp_cmp_minmax_d.sv
// Self-checking bench for fp_cmp_minmax_d: directed cases, backpressure,
// mid-flight reset and a randomized scoreboard run against a real-valued model.
module tb_fp_cmp_minmax_d;
    localparam logic [63:0] CANON = 64'h7FF8000000000000;
    localparam logic [63:0] ONE   = 64'h3FF0000000000000;
    localparam logic [63:0] TWO   = 64'h4000000000000000;
    localparam logic [63:0] QNAN  = 64'h7FF8000000000000;
    localparam logic [63:0] SNAN  = 64'h7FF0000000000001;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fp_cmp_minmax_d_if bus();

    fp_cmp_minmax_d dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_r_q[$];
    logic [4:0]  exp_f_q[$];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Model built from the IEEE ordering via real arithmetic.
    function automatic void ref_model(input logic [63:0] a, input logic [63:0] b,
                                      input logic [2:0] op,
                                      output logic [63:0] r, output logic [4:0] f);
        logic an, bn, as_, bs_, lt, eq;
        real ra, rb;
        an  = (a[62:52] == 11'h7FF) && (a[51:0] != 52'd0);
        bn  = (b[62:52] == 11'h7FF) && (b[51:0] != 52'd0);
        as_ = an && !a[51];
        bs_ = bn && !b[51];
        ra  = $bitstoreal(a);
        rb  = $bitstoreal(b);
        lt  = 1'b0;
        eq  = 1'b0;
        if (!an && !bn) begin
            lt = (ra < rb);
            eq = (ra == rb);
        end
        r = 64'd0;
        f = 5'd0;
        case (op)
            3'd0: begin r = {63'd0, eq};        f = {as_ || bs_, 4'b0}; end
            3'd1: begin r = {63'd0, lt};        f = {an || bn, 4'b0};   end
            3'd2: begin r = {63'd0, lt || eq};  f = {an || bn, 4'b0};   end
            3'd3, 3'd4: begin
                if (an && bn)      r = CANON;
                else if (an)       r = b;
                else if (bn)       r = a;
                else if (eq)       r = (op == 3'd3) ? (a[63] ? a : b) : (a[63] ? b : a);
                else if (op == 3'd3) r = lt ? a : b;
                else               r = lt ? b : a;
                f = {as_ || bs_, 4'b0};
            end
            default: begin r = 64'd0; f = 5'd0; end
        endcase
    endfunction

    function automatic logic [63:0] rand_val();
        logic [63:0] v;
        v = {$urandom, $urandom};
        case ($urandom_range(0, 9))
            0: ;
            2: begin v[62:0] = 63'd0; end
            3: begin v[62:0] = {11'h7FF, 52'd0}; end
            4: begin v[62:51] = 12'hFFF; end
            5: begin
                v[62:52] = 11'h7FF;
                v[51] = 1'b0;
                if (v[50:0] == 51'd0) v[0] = 1'b1;
            end
            6: begin v[62:52] = 11'd0; end
            default: begin v[62:52] = 11'(1020 + $urandom_range(0, 6)); end
        endcase
        return v;
    endfunction

    function automatic void get_vec(input int i, output logic [63:0] a, output logic [63:0] b,
                                    output logic [2:0] op, output logic [63:0] r,
                                    output logic [4:0] f);
        f = 5'd0;
        case (i)
            0:  begin a = ONE;  b = TWO;  op = 3'd1; r = 64'd1; end
            1:  begin a = TWO;  b = ONE;  op = 3'd1; r = 64'd0; end
            2:  begin a = 64'h0; b = 64'h8000000000000000; op = 3'd0; r = 64'd1; end
            3:  begin a = 64'h0; b = 64'h8000000000000000; op = 3'd3; r = 64'h8000000000000000; end
            4:  begin a = 64'h8000000000000000; b = 64'h0; op = 3'd3; r = 64'h8000000000000000; end
            5:  begin a = 64'h0; b = 64'h8000000000000000; op = 3'd4; r = 64'h0; end
            6:  begin a = 64'h8000000000000000; b = 64'h0; op = 3'd4; r = 64'h0; end
            7:  begin a = 64'h7FF8000000000001; b = 64'h4008000000000000; op = 3'd3; r = 64'h4008000000000000; end
            8:  begin a = 64'h7FF0000000000001; b = 64'h7FF8000000000000; op = 3'd4; r = 64'h7FF8000000000000; f = 5'b10000; end
            9:  begin a = QNAN; b = ONE; op = 3'd2; r = 64'd0; f = 5'b10000; end
            10: begin a = QNAN; b = ONE; op = 3'd0; r = 64'd0; end
            11: begin a = SNAN; b = SNAN; op = 3'd0; r = 64'd0; f = 5'b10000; end
            12: begin a = 64'hC000000000000000; b = 64'hBFF0000000000000; op = 3'd1; r = 64'd1; end
            13: begin a = 64'hFFF0000000000000; b = 64'h1; op = 3'd4; r = 64'h1; end
            14: begin a = ONE;  b = TWO;  op = 3'd5; r = 64'd0; end
            15: begin a = ONE;  b = ONE;  op = 3'd2; r = 64'd1; end
            default: begin a = QNAN; b = SNAN; op = 3'd3; r = CANON; f = 5'b10000; end
        endcase
    endfunction

    // Applies one cycle of stimulus and reports what the handshake saw before the edge.
    task automatic drive_cycle(input logic v, input logic [63:0] a, input logic [63:0] b,
                               input logic [2:0] op, input logic ordy,
                               output logic acc, output logic dlv,
                               output logic [63:0] res, output logic [4:0] ff);
        bus.in_valid  = v;
        bus.in_a      = a;
        bus.in_b      = b;
        bus.in_op     = op;
        bus.out_ready = ordy;
        #1;
        acc = v && bus.in_ready;
        dlv = bus.out_valid && ordy;
        res = bus.out_result;
        ff  = bus.out_fflags;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_a = 64'd0; bus.in_b = 64'd0; bus.in_op = 3'd0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
        checks++; if (bus.out_result !== 64'd0) begin errors++; $display("FAIL reset_out_result got %h want 0", bus.out_result); end
        checks++; if (bus.out_fflags !== 5'd0) begin errors++; $display("FAIL reset_out_fflags got %b want 0", bus.out_fflags); end
        $display("TXN reset done");
    endtask

    task automatic test_directed();
        logic [63:0] a, b, r, res;
        logic [2:0]  op;
        logic [4:0]  f, ff;
        logic acc, dlv;
        for (int i = 0; i < 17; i++) begin
            get_vec(i, a, b, op, r, f);
            drive_cycle(1'b1, a, b, op, 1'b1, acc, dlv, res, ff);
            checks++; if (acc !== 1'b1) begin errors++; $display("FAIL dir%0d_accept got %b want 1", i, acc); end
            drive_cycle(1'b0, 64'd0, 64'd0, 3'd0, 1'b1, acc, dlv, res, ff);
            checks++; if (dlv !== 1'b0) begin errors++; $display("FAIL dir%0d_early_valid got %b want 0", i, dlv); end
            drive_cycle(1'b0, 64'd0, 64'd0, 3'd0, 1'b1, acc, dlv, res, ff);
            checks++; if (dlv !== 1'b1) begin errors++; $display("FAIL dir%0d_latency got out_valid %b want 1", i, dlv); end
            checks++; if (res !== r) begin errors++; $display("FAIL dir%0d_result op %0d got %h want %h", i, op, res, r); end
            checks++; if (ff !== f) begin errors++; $display("FAIL dir%0d_fflags got %b want %b", i, ff, f); end
            $display("TXN dir%0d op=%0d a=%h b=%h res=%h ff=%b", i, op, a, b, res, ff);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] a[3], b[3], er[3], res;
        logic [2:0]  op[3];
        logic [4:0]  ef[3], ff;
        logic acc, dlv;
        a[0] = ONE;                 b[0] = TWO;                 op[0] = 3'd1;
        a[1] = 64'hC000000000000000; b[1] = 64'hBFF0000000000000; op[1] = 3'd4;
        a[2] = ONE;                 b[2] = ONE;                 op[2] = 3'd0;
        for (int i = 0; i < 3; i++) ref_model(a[i], b[i], op[i], er[i], ef[i]);

        drive_cycle(1'b1, a[0], b[0], op[0], 1'b0, acc, dlv, res, ff);
        checks++; if (acc !== 1'b1) begin errors++; $display("FAIL bp_accept0 got %b want 1", acc); end
        drive_cycle(1'b1, a[1], b[1], op[1], 1'b0, acc, dlv, res, ff);
        checks++; if (acc !== 1'b1) begin errors++; $display("FAIL bp_accept1 got %b want 1", acc); end
        for (int k = 0; k < 4; k++) begin
            drive_cycle(1'b1, a[2], b[2], op[2], 1'b0, acc, dlv, res, ff);
            checks++; if (acc !== 1'b0) begin errors++; $display("FAIL bp_stall%0d_in_ready got accept %b want 0", k, acc); end
            checks++; if (res !== er[0] || ff !== ef[0]) begin errors++; $display("FAIL bp_hold%0d got %h/%b want %h/%b", k, res, ff, er[0], ef[0]); end
        end
        drive_cycle(1'b1, a[2], b[2], op[2], 1'b1, acc, dlv, res, ff);
        checks++; if (acc !== 1'b1) begin errors++; $display("FAIL bp_accept2 got %b want 1", acc); end
        for (int k = 0; k < 3; k++) begin
            if (k > 0) drive_cycle(1'b0, 64'd0, 64'd0, 3'd0, 1'b1, acc, dlv, res, ff);
            checks++; if (dlv !== 1'b1) begin errors++; $display("FAIL bp_drain%0d_valid got %b want 1", k, dlv); end
            checks++; if (res !== er[k] || ff !== ef[k]) begin errors++; $display("FAIL bp_drain%0d_data got %h/%b want %h/%b", k, res, ff, er[k], ef[k]); end
            $display("TXN bp%0d res=%h ff=%b", k, res, ff);
        end
        drive_cycle(1'b0, 64'd0, 64'd0, 3'd0, 1'b1, acc, dlv, res, ff);
        checks++; if (dlv !== 1'b0) begin errors++; $display("FAIL bp_no_duplicate got out_valid %b want 0", dlv); end
    endtask

    task automatic test_reset_mid();
        logic [63:0] res;
        logic [4:0]  ff;
        logic acc, dlv;
        drive_cycle(1'b1, ONE, TWO, 3'd1, 1'b0, acc, dlv, res, ff);
        drive_cycle(1'b1, TWO, ONE, 3'd4, 1'b0, acc, dlv, res, ff);
        checks++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin errors++; $display("FAIL rm_fill got valid %b ready %b want 1 0", bus.out_valid, bus.in_ready); end
        rst = 1'b1;
        bus.in_valid = 1'b1; bus.in_a = ONE; bus.in_b = ONE; bus.in_op = 3'd0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rm_out_valid got %b want 0", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rm_in_ready got %b want 1", bus.in_ready); end
        checks++; if (bus.out_result !== 64'd0 || bus.out_fflags !== 5'd0) begin errors++; $display("FAIL rm_outputs got %h/%b want 0/0", bus.out_result, bus.out_fflags); end
        drive_cycle(1'b1, ONE, ONE, 3'd0, 1'b1, acc, dlv, res, ff);
        checks++; if (acc !== 1'b1) begin errors++; $display("FAIL rm_accept got %b want 1", acc); end
        drive_cycle(1'b0, 64'd0, 64'd0, 3'd0, 1'b1, acc, dlv, res, ff);
        checks++; if (dlv !== 1'b0) begin errors++; $display("FAIL rm_early got out_valid %b want 0", dlv); end
        drive_cycle(1'b0, 64'd0, 64'd0, 3'd0, 1'b1, acc, dlv, res, ff);
        checks++; if (dlv !== 1'b1 || res !== 64'd1 || ff !== 5'd0) begin errors++; $display("FAIL rm_feq got v%b %h/%b want v1 1/0", dlv, res, ff); end
        $display("TXN reset_mid feq res=%h ff=%b", res, ff);
    endtask

    task automatic test_random();
        logic [63:0] a, b, r, res;
        logic [2:0]  op;
        logic [4:0]  f, ff;
        logic acc, dlv, v, ordy;
        int n = 0;
        for (int cyc = 0; cyc < 620; cyc++) begin
            a  = rand_val();
            case ($urandom_range(0, 7))
                0, 1: b = a;
                2:    b = a ^ 64'h8000000000000000;
                default: b = rand_val();
            endcase
            op   = 3'($urandom_range(0, 7));
            v    = (cyc < 600) && ($urandom_range(0, 3) != 0);
            ordy = (cyc >= 600) || ($urandom_range(0, 3) != 0);
            drive_cycle(v, a, b, op, ordy, acc, dlv, res, ff);
            if (dlv) begin
                checks++;
                if (exp_r_q.size() == 0) begin
                    errors++; $display("FAIL rnd_unexpected got %h/%b want no output", res, ff);
                end else begin
                    r = exp_r_q.pop_front();
                    f = exp_f_q.pop_front();
                    if (res !== r || ff !== f) begin
                        errors++; $display("FAIL rnd%0d got %h/%b want %h/%b", n, res, ff, r, f);
                    end
                    $display("TXN rnd%0d res=%h ff=%b", n, res, ff);
                    n++;
                end
            end
            if (acc) begin
                ref_model(a, b, op, r, f);
                exp_r_q.push_back(r);
                exp_f_q.push_back(f);
            end
        end
        checks++;
        if (exp_r_q.size() != 0) begin errors++; $display("FAIL rnd_drain got %0d pending want 0", exp_r_q.size()); end
        checks++;
        if (n < 100) begin errors++; $display("FAIL rnd_count got %0d results want >=100", n); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
